// File: rtl/pipe_hazard_if.sv
// Hazard-controller bundle: ID-stage operand/destination info, branch outcome,
// and the stall/flush/forward controls returned to the pipeline.
interface pipe_hazard_if;
    logic       id_valid;
    logic [2:0] id_read_addr1;
    logic       id_read_en1;
    logic [2:0] id_read_addr2;
    logic       id_read_en2;
    logic [2:0] id_write_addr;
    logic       id_write_en;
    logic       id_mem_read;
    logic       branch_taken;
    logic       stall;
    logic       flush_if_id;
    logic       flush_id_mex;
    logic [1:0] fwd_sel1;
    logic [1:0] fwd_sel2;

    modport master (
        output id_valid, id_read_addr1, id_read_en1, id_read_addr2, id_read_en2,
               id_write_addr, id_write_en, id_mem_read, branch_taken,
        input  stall, flush_if_id, flush_id_mex, fwd_sel1, fwd_sel2
    );

    modport slave (
        input  id_valid, id_read_addr1, id_read_en1, id_read_addr2, id_read_en2,
               id_write_addr, id_write_en, id_mem_read, branch_taken,
        output stall, flush_if_id, flush_id_mex, fwd_sel1, fwd_sel2
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the ID -> MEX -> WB pipeline.
// Define HAZARD_FWD_EN for operand forwarding; otherwise RAW hazards stall until WB retires.
module pipe_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    pipe_hazard_if.slave     hz,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef struct packed {
        logic       valid;
        logic [2:0] addr;
        logic       is_load;
    } sb_entry_t;

    typedef enum logic [0:0] {StRun, StFlush} state_t;

    // FLUSH-state cycles remaining after the branch cycle itself
    localparam logic [1:0] FlushLoad = 2'(FLUSH_CYCLES - 1);

    sb_entry_t        mex_q, mex_d;
    logic             wb_valid_q;
    logic [2:0]       wb_addr_q;
    state_t           state_q, state_d;
    logic [1:0]       fcnt_q, fcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic       hit_m1, hit_m2, hit_w1, hit_w2;
    logic       flushing, flush_event, raw_stall, stall;
    logic [1:0] sel1, sel2;

    assign hit_m1 = hz.id_read_en1 & mex_q.valid & (hz.id_read_addr1 == mex_q.addr);
    assign hit_m2 = hz.id_read_en2 & mex_q.valid & (hz.id_read_addr2 == mex_q.addr);
    assign hit_w1 = hz.id_read_en1 & wb_valid_q & (hz.id_read_addr1 == wb_addr_q);
    assign hit_w2 = hz.id_read_en2 & wb_valid_q & (hz.id_read_addr2 == wb_addr_q);

    // branch_taken during FLUSH is ignored for sequencing but the flush is already on
    assign flushing = (state_q == StFlush) | hz.branch_taken;

`ifdef HAZARD_FWD_EN
    always_comb begin
        raw_stall = hz.id_valid & mex_q.is_load & (hit_m1 | hit_m2);
        sel1 = 2'b00;
        sel2 = 2'b00;
        if (hit_m1 && !mex_q.is_load) sel1 = 2'b01;
        else if (hit_w1)              sel1 = 2'b10;
        if (hit_m2 && !mex_q.is_load) sel2 = 2'b01;
        else if (hit_w2)              sel2 = 2'b10;
    end
`else
    logic unused_is_load;
    assign unused_is_load = mex_q.is_load;
    assign raw_stall = hz.id_valid & (hit_m1 | hit_m2 | hit_w1 | hit_w2);
    assign sel1 = 2'b00;
    assign sel2 = 2'b00;
`endif

    assign stall           = raw_stall & ~flushing;
    assign hz.stall        = stall;
    assign hz.flush_if_id  = flushing;
    assign hz.flush_id_mex = flushing;
    assign hz.fwd_sel1     = flushing ? 2'b00 : sel1;
    assign hz.fwd_sel2     = flushing ? 2'b00 : sel2;

    always_comb begin
        mex_d         = '0;
        mex_d.valid   = hz.id_valid & hz.id_write_en & ~stall & ~flushing;
        if (mex_d.valid) begin
            mex_d.addr    = hz.id_write_addr;
            mex_d.is_load = hz.id_mem_read;
        end
    end

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        flush_event = 1'b0;
        unique case (state_q)
            StRun: begin
                if (hz.branch_taken) begin
                    flush_event = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = StFlush;
                        fcnt_d  = FlushLoad;
                    end
                end
            end
            StFlush: begin
                fcnt_d = fcnt_q - 2'd1;
                if (fcnt_d == 2'd0) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mex_q       <= '0;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            state_q     <= StRun;
            fcnt_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            mex_q      <= mex_d;
            wb_valid_q <= mex_q.valid;
            wb_addr_q  <= mex_q.addr;
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            if (stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_event && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule
